yarp_regfile_sb: RTL
====================

# yarp_regfile_sb

Parametrised, multi-read-port register file for the YARP core, with an integrated write-pending scoreboard. It holds `NREGS` architectural registers of `XLEN` bits and serves `NRD` combinational read ports. Each destination register carries a busy bit that is set when an instruction reserves it at issue and cleared when its result is written back. It sits between decode/issue (reads, reservations, stall decisions) and writeback.

## Interface
Parameters:
- `XLEN`, default 32, register width in bits.
- `NREGS`, default 32, number of registers; a power of two, ≥ 2. `AW = $clog2(NREGS)` is a localparam.
- `NRD`, default 2, number of read ports; ≥ 1.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rs_addr_i`  in  `NRD*AW`  read addresses; port k uses bits `[k*AW +: AW]`.
- `rs_data_o`  out  `NRD*XLEN`  read data; port k uses bits `[k*XLEN +: XLEN]`.
- `rs_busy_o`  out  `NRD`  bit k is 1 when port k's register has a pending write.
- `rsv_en_i`  in  1  reserve request; marks `rsv_addr_i` busy.
- `rsv_addr_i`  in  `AW`  destination register to reserve.
- `wr_en_i`  in  1  writeback enable.
- `rd_addr_i`  in  `AW`  writeback address.
- `wr_data_i`  in  `XLEN`  writeback data.
- `flush_i`  in  1  clears every busy bit; register data is kept.
- `busy_cnt_o`  out  `AW+1`  registered count of busy registers.
- `rsv_err_o`  out  1  registered one-cycle pulse: a reservation hit an already-busy register.

## Operation
- **Reset (async, reset_n=0):** every register is 0, every busy bit is 0, `busy_cnt_o` = 0, `rsv_err_o` = 0.
- **Read:** combinational. Address 0 always returns 0 with busy = 0. All other addresses return the stored value and busy bit.
- **Write:** when `wr_en_i` is 1 and `rd_addr_i` ≠ 0, `wr_data_i` is stored and `busy[rd_addr_i]` is cleared. Writes to x0 are discarded, so x0 storage stays 0.
- **Reserve:** when `rsv_en_i` is 1 and `rsv_addr_i` ≠ 0, the busy bit is set. If the bit was already set (the writeback that cycle does not clear it), `rsv_err_o` pulses 1 on the next cycle and the bit stays set. A reservation of x0 is ignored.
- **Priority per register bit, applied to the next state:**
  1. Reserve sets the bit.
  2. Otherwise flush clears it.
  3. Otherwise writeback clears it.
- **Same-cycle cases:**
  - Reserve and writeback to the same address: data is written and the bit stays 1, because it now tracks the new producer.
  - Flush and reserve in the same cycle: only the reserved register ends busy.
- **`busy_cnt_o`:** equals the popcount of the next-state busy vector, registered. It never exceeds `NREGS-1`.

## Timing
- Read data and busy flags are available in the same cycle, with no latency.
- A write becomes visible on reads the cycle after the edge, unless bypass is enabled (see Configuration).
- Busy bits, `busy_cnt_o` and `rsv_err_o` update on the clock edge, one cycle after the request.
- If reset is asserted mid-operation, all state clears immediately and requests in flight are lost. The first edge after deassertion behaves normally.

## Configuration
- **`YARP_RF_BYPASS_EN` defined:** when a read port's address equals `rd_addr_i`, `wr_en_i` = 1 and the address ≠ 0:
  - that port returns `wr_data_i` in the same cycle;
  - its `rs_busy_o` bit is 0, unless `rsv_en_i` targets the same address that cycle.
- **Undefined:** no forwarding. The port returns the old stored value and the registered busy bit.

## Test plan
- **Reset:** pulse `reset_n` low between edges, then read all addresses -> data 0, `rs_busy_o` = 0, `busy_cnt_o` = 0.
- **Write/read:** write `0xDEADBEEF` to x5, next cycle read x5 on both ports -> `0xDEADBEEF`. Write `0x1234` to x0 -> reads of x0 return 0.
- **Scoreboard:**
  - Reserve x7 -> next cycle `rs_busy_o` = 1 for x7 and `busy_cnt_o` = 1.
  - Write x7 = `0x55` -> next cycle busy = 0, count = 0, data = `0x55`.
- **Collisions:**
  - Reserve x3 twice in consecutive cycles -> `rsv_err_o` pulses 1 for one cycle.
  - Reserve and write x3 in the same cycle -> x3 stays busy and its data is updated.
- **Flush:**
  - Reserve x1, x2, x4 -> count = 3.
  - Flush together with reserve x9 -> count = 1 and only x9 is busy; x1 data is unchanged.
- **Bypass:** x6 busy holding `0xA`; write x6 = `0xB` while reading x6 -> with the macro, same-cycle data `0xB` and busy 0; without it, `0xA` and busy 1.

Source files
------------

// File: rtl/yarp_regfile_sb.sv
`timescale 1ns/1ps
// yarp_regfile_sb
// Multi-read-port register file with an integrated write-pending scoreboard.
// Holds NREGS registers of XLEN bits; x0 reads as zero and is never busy.
// Each register has a busy bit. A reservation at issue sets it. A flush or
// the register's writeback clears it.
//
// Optional feature: define YARP_RF_BYPASS_EN to forward same-cycle writeback
// data (and a cleared busy flag) onto matching read ports.
//
// Ports:
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   rs_addr_i      NRD packed read addresses (port k at [k*AW +: AW])
//   rs_data_o      NRD packed read data (port k at [k*XLEN +: XLEN]), combinational
//   rs_busy_o      per-port busy flag, combinational
//   rsv_en_i/rsv_addr_i              reserve destination register
//   wr_en_i/rd_addr_i/wr_data_i      writeback
//   flush_i        clear all busy bits (data kept)
//   busy_cnt_o     registered popcount of the busy vector
//   rsv_err_o      registered pulse: reservation hit an already-busy register
module yarp_regfile_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NRD*$clog2(NREGS)-1:0] rs_addr_i,
   output logic [NRD*XLEN-1:0]        rs_data_o,
   output logic [NRD-1:0]             rs_busy_o,
   input  logic                       rsv_en_i,
   input  logic [$clog2(NREGS)-1:0]   rsv_addr_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(NREGS)-1:0]   rd_addr_i,
   input  logic [XLEN-1:0]            wr_data_i,
   input  logic                       flush_i,
   output logic [$clog2(NREGS):0]     busy_cnt_o,
   output logic                       rsv_err_o
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs_r [NREGS];
   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] busy_nxt_s;
   logic [AW:0]      busy_cnt_r;
   logic             rsv_err_r;
   logic             wr_act_s;
   logic             rsv_act_s;
   logic             rsv_err_nxt_s;

   function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
      logic [AW:0] c;
      c = {(AW+1){1'b0}};
      for (int i = 0; i < NREGS; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Accesses that target x0 are dropped here so nothing downstream sees them.
   assign wr_act_s  = wr_en_i  && (rd_addr_i  != {AW{1'b0}});
   assign rsv_act_s = rsv_en_i && (rsv_addr_i != {AW{1'b0}});

   // Next-state busy vector: reserve beats flush, flush beats writeback.
   always_comb begin
      busy_nxt_s = busy_r;
      for (int i = 1; i < NREGS; i++) begin
         if (rsv_act_s && (rsv_addr_i == AW'(i))) begin
            busy_nxt_s[i] = 1'b1;
         end else if (flush_i) begin
            busy_nxt_s[i] = 1'b0;
         end else if (wr_act_s && (rd_addr_i == AW'(i))) begin
            busy_nxt_s[i] = 1'b0;
         end else begin
            busy_nxt_s[i] = busy_r[i];
         end
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Double reservation is an error unless the same-cycle writeback retires the old producer.
   always_comb begin
      if (rsv_act_s && busy_r[rsv_addr_i] && !(wr_act_s && (rd_addr_i == rsv_addr_i))) begin
         rsv_err_nxt_s = 1'b1;
      end else begin
         rsv_err_nxt_s = 1'b0;
      end
   end

   // Register storage; x0 is only ever written by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wr_act_s) begin
         regs_r[rd_addr_i] <= wr_data_i;
      end
   end

   // Scoreboard state, busy count and error pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_r     <= {NREGS{1'b0}};
         busy_cnt_r <= {(AW+1){1'b0}};
         rsv_err_r  <= 1'b0;
      end else begin
         busy_r     <= busy_nxt_s;
         busy_cnt_r <= popcount(busy_nxt_s);
         rsv_err_r  <= rsv_err_nxt_s;
      end
   end

   assign busy_cnt_o = busy_cnt_r;
   assign rsv_err_o  = rsv_err_r;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr_s;
      logic [XLEN-1:0] data_s;
      logic            busy_s;

      assign addr_s = rs_addr_i[k*AW +: AW];

      // Read mux for one port; x0 is forced to zero / not busy.
      always_comb begin
         data_s = {XLEN{1'b0}};
         busy_s = 1'b0;
         if (addr_s == {AW{1'b0}}) begin
            data_s = {XLEN{1'b0}};
            busy_s = 1'b0;
`ifdef YARP_RF_BYPASS_EN
         end else if (wr_act_s && (rd_addr_i == addr_s)) begin
            // Forwarded result; still busy if a new producer reserves it now.
            data_s = wr_data_i;
            busy_s = rsv_act_s && (rsv_addr_i == addr_s);
`endif
         end else begin
            data_s = regs_r[addr_s];
            busy_s = busy_r[addr_s];
         end
      end

      assign rs_data_o[k*XLEN +: XLEN] = data_s;
      assign rs_busy_o[k]              = busy_s;
   end

endmodule
